// File: rtl/range_sched_pkg.sv
// Shared types and width helpers for the range-finder session scheduler.
package range_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_STREAM,
        S_CLOSE,
        S_REPORT
    } state_e;

    function automatic int cnt_w(input int max_samples);
        return $clog2(max_samples + 1);
    endfunction

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/range_session_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i+1, wrapping mod NREQ.
module rr_arbiter
    import range_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    int            cand;
    logic [IDW-1:0] cidx;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        cidx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(ptr_i) + i) % NREQ;
            cidx = IDW'(cand);
            if (!valid_o && req_i[cidx]) begin
                valid_o       = 1'b1;
                grant_o[cidx] = 1'b1;
                idx_o         = cidx;
            end
        end
    end

endmodule

// File: rtl/range_session_sched.sv
// Round-robin session scheduler in front of the shared range-finder datapath.
// Define RANGE_SCHED_TIMEOUT_EN to abort sessions after TIMEOUT idle cycles.
module range_session_sched
    import range_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 10,
    parameter int MAX_SAMPLES = 255,
    parameter int TIMEOUT     = 16,
    localparam int CNTW = cnt_w(MAX_SAMPLES),
    localparam int IDW  = id_w(NREQ)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ-1:0]       valid_i,
    input  logic [NREQ-1:0]       last_i,
    input  logic [NREQ*WIDTH-1:0] data_i,
    output logic [NREQ-1:0]       grant_o,
    output logic                  ready_o,
    output logic [WIDTH-1:0]      rf_data_o,
    output logic                  rf_go_o,
    output logic                  rf_finish_o,
    input  logic [WIDTH-1:0]      rf_range_i,
    input  logic                  rf_error_i,
    output logic                  done_o,
    output logic [IDW-1:0]        done_id_o,
    output logic [WIDTH-1:0]      result_o,
    output logic                  result_err_o,
    output logic                  result_trunc_o,
    output logic [CNTW-1:0]       count_o
);

    // state    | meaning
    // S_IDLE   | no owner; arbitrate pending requests
    // S_FIRST  | owner granted, waiting for first sample (drives rf_go)
    // S_STREAM | accepting further samples until last or cap
    // S_CLOSE  | re-present held sample with rf_finish
    // S_REPORT | done strobe; release grant, advance pointer

    state_e           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IDW-1:0]   gidx_q, gidx_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             trunc_q, trunc_d;

    logic             done_q, done_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_err_q, result_err_d;
    logic             result_trunc_q, result_trunc_d;
    logic [CNTW-1:0]  count_out_q, count_out_d;

`ifdef RANGE_SCHED_TIMEOUT_EN
    localparam int TMRW = $clog2(TIMEOUT + 1);
    logic [TMRW-1:0]  tmr_q, tmr_d;
    logic             tmo_q, tmo_d;
`endif

    logic [NREQ-1:0]  arb_grant;
    logic [IDW-1:0]   arb_idx;
    logic             arb_valid;

    logic             v_g, l_g;
    logic [WIDTH-1:0] d_g;
    logic [CNTW-1:0]  cnt_inc;
    logic             cap_hit;
    logic             fin, fin_trunc;
    logic [CNTW-1:0]  fin_cnt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign v_g     = valid_i[gidx_q];
    assign l_g     = last_i[gidx_q];
    assign d_g     = data_i[int'(gidx_q)*WIDTH +: WIDTH];
    assign cnt_inc = count_q + CNTW'(1);
    assign cap_hit = (cnt_inc == CNTW'(MAX_SAMPLES));

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        gidx_d         = gidx_q;
        ptr_d          = ptr_q;
        count_d        = count_q;
        hold_d         = hold_q;
        trunc_d        = trunc_q;
        done_d         = 1'b0;
        done_id_d      = done_id_q;
        result_d       = result_q;
        result_err_d   = result_err_q;
        result_trunc_d = result_trunc_q;
        count_out_d    = count_out_q;
        ready_o        = 1'b0;
        rf_go_o        = 1'b0;
        rf_finish_o    = 1'b0;
        rf_data_o      = hold_q;
        fin            = 1'b0;
        fin_trunc      = trunc_q;
        fin_cnt        = count_q;
`ifdef RANGE_SCHED_TIMEOUT_EN
        tmr_d          = tmr_q;
        tmo_d          = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    gidx_d  = arb_idx;
                    count_d = '0;
                    trunc_d = 1'b0;
                    state_d = S_FIRST;
`ifdef RANGE_SCHED_TIMEOUT_EN
                    tmr_d   = TMRW'(TIMEOUT);
                    tmo_d   = 1'b0;
`endif
                end
            end
            S_FIRST: begin
                ready_o = 1'b1;
                if (v_g) begin
                    rf_data_o = d_g;
                    rf_go_o   = 1'b1;
                    hold_d    = d_g;
                    count_d   = CNTW'(1);
                    // go and finish never share a cycle, so a one-sample session closes next cycle
                    if (l_g || (MAX_SAMPLES == 1)) begin
                        trunc_d = !l_g;
                        state_d = S_CLOSE;
                    end else begin
                        state_d = S_STREAM;
                    end
`ifdef RANGE_SCHED_TIMEOUT_EN
                    tmr_d = TMRW'(TIMEOUT);
                end else if (tmr_q == TMRW'(1)) begin
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TMRW'(1);
`endif
                end
            end
            S_STREAM: begin
                ready_o = 1'b1;
                if (v_g) begin
                    rf_data_o = d_g;
                    hold_d    = d_g;
                    count_d   = cnt_inc;
                    if (l_g || cap_hit) begin
                        rf_finish_o = 1'b1;
                        fin         = 1'b1;
                        fin_trunc   = cap_hit && !l_g;
                        fin_cnt     = cnt_inc;
                    end
`ifdef RANGE_SCHED_TIMEOUT_EN
                    tmr_d = TMRW'(TIMEOUT);
                end else if (tmr_q == TMRW'(1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_CLOSE;
                end else begin
                    tmr_d = tmr_q - TMRW'(1);
`endif
                end
            end
            S_CLOSE: begin
                rf_finish_o = 1'b1;
                fin         = 1'b1;
            end
            S_REPORT: begin
                ptr_d   = gidx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            done_d         = 1'b1;
            done_id_d      = gidx_q;
            result_d       = rf_range_i;
`ifdef RANGE_SCHED_TIMEOUT_EN
            result_err_d   = rf_error_i | tmo_q;
`else
            result_err_d   = rf_error_i;
`endif
            result_trunc_d = fin_trunc;
            count_out_d    = fin_cnt;
            grant_d        = '0;
            state_d        = S_REPORT;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            grant_q        <= '0;
            gidx_q         <= '0;
            ptr_q          <= IDW'(NREQ - 1);
            count_q        <= '0;
            hold_q         <= '0;
            trunc_q        <= 1'b0;
            done_q         <= 1'b0;
            done_id_q      <= '0;
            result_q       <= '0;
            result_err_q   <= 1'b0;
            result_trunc_q <= 1'b0;
            count_out_q    <= '0;
`ifdef RANGE_SCHED_TIMEOUT_EN
            tmr_q          <= '0;
            tmo_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            gidx_q         <= gidx_d;
            ptr_q          <= ptr_d;
            count_q        <= count_d;
            hold_q         <= hold_d;
            trunc_q        <= trunc_d;
            done_q         <= done_d;
            done_id_q      <= done_id_d;
            result_q       <= result_d;
            result_err_q   <= result_err_d;
            result_trunc_q <= result_trunc_d;
            count_out_q    <= count_out_d;
`ifdef RANGE_SCHED_TIMEOUT_EN
            tmr_q          <= tmr_d;
            tmo_q          <= tmo_d;
`endif
        end
    end

    assign grant_o        = grant_q;
    assign done_o         = done_q;
    assign done_id_o      = done_id_q;
    assign result_o       = result_q;
    assign result_err_o   = result_err_q;
    assign result_trunc_o = result_trunc_q;
    assign count_o        = count_out_q;

endmodule

// File: tb/tb_range_session_sched.sv
// Directed bench for range_session_sched with a behavioural min/max range-finder datapath.
module tb_range_session_sched;

    localparam int NREQ = 4;
    localparam int W    = 10;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [3:0]      req_i, valid_i, last_i;
    logic [4*W-1:0]  data_i;
    logic [3:0]      grant_o;
    logic            ready_o, rf_go_o, rf_finish_o;
    logic [W-1:0]    rf_data_o, rf_range_i, result_o;
    logic            rf_error_i;
    logic            done_o, result_err_o, result_trunc_o;
    logic [1:0]      done_id_o;
    logic [2:0]      count_o;

    int total = 0;
    int bad   = 0;

    range_session_sched #(.NREQ(4), .WIDTH(W), .MAX_SAMPLES(4), .TIMEOUT(2)) dut (
        .clock_i(clk), .reset_i(reset_i), .req_i(req_i), .valid_i(valid_i),
        .last_i(last_i), .data_i(data_i), .grant_o(grant_o), .ready_o(ready_o),
        .rf_data_o(rf_data_o), .rf_go_o(rf_go_o), .rf_finish_o(rf_finish_o),
        .rf_range_i(rf_range_i), .rf_error_i(rf_error_i), .done_o(done_o),
        .done_id_o(done_id_o), .result_o(result_o), .result_err_o(result_err_o),
        .result_trunc_o(result_trunc_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Range-finder model: min/max over data_in from go through finish; range is combinational.
    logic [W-1:0] mn_q, mx_q, lo, hi;
    logic         run_q;
    always_comb begin
        lo = (run_q && rf_data_o > mn_q) ? mn_q : rf_data_o;
        hi = (run_q && rf_data_o < mx_q) ? mx_q : rf_data_o;
        rf_range_i = (run_q && !rf_go_o) ? hi - lo : '0;
    end
    always @(posedge clk) begin
        if (reset_i) run_q <= 1'b0;
        else if (rf_go_o) begin
            mn_q <= rf_data_o; mx_q <= rf_data_o; run_q <= 1'b1;
        end else if (run_q) begin
            mn_q <= lo; mx_q <= hi;
            if (rf_finish_o) run_q <= 1'b0;
        end
    end

    task automatic drive(input int idx, input logic [W-1:0] v, input logic l);
        valid_i = '0; last_i = '0;
        valid_i[idx] = 1'b1; last_i[idx] = l;
        data_i[idx*W +: W] = v;
    endtask

    task automatic idle_in();
        valid_i = '0; last_i = '0;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant_o == 4'b0 && n < 8) begin
            @(negedge clk); n++;
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; req_i = '0; rf_error_i = 1'b0; data_i = '0; idle_in();
        @(negedge clk); @(negedge clk);
        total++; if (grant_o !== 4'b0) begin bad++; $display("FAIL rst_grant got=%0h want=0", grant_o); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", ready_o); end
        total++; if (done_o !== 1'b0 || result_o !== '0 || count_o !== '0) begin
            bad++; $display("FAIL rst_result done=%0b result=%0d count=%0d want all 0", done_o, result_o, count_o);
        end
        reset_i = 1'b0;
    endtask

    task automatic test_alternate();
        int n;
        int exp_id[4] = '{0, 3, 0, 3};
        req_i = 4'b1001;
        for (int s = 0; s < 4; s++) begin
            wait_grant(n);
            total++; if (n >= 8) begin bad++; $display("FAIL alt_grant_wait got=timeout want=grant"); end
            total++; if (grant_o !== 4'(1 << exp_id[s])) begin
                bad++; $display("FAIL alt_grant s=%0d got=%0h want=%0h", s, grant_o, 4'(1 << exp_id[s]));
            end
            drive(exp_id[s], W'(10 + s), 1'b0); #1;
            total++; if (rf_go_o !== 1'b1) begin bad++; $display("FAIL alt_go s=%0d got=%0b want=1", s, rf_go_o); end
            @(negedge clk);
            drive(exp_id[s], W'(20 + 5*s), 1'b1); #1;
            total++; if (rf_finish_o !== 1'b1) begin bad++; $display("FAIL alt_finish s=%0d got=%0b want=1", s, rf_finish_o); end
            @(negedge clk); idle_in();
            if (s == 3) req_i = '0;
            total++; if (done_o !== 1'b1 || done_id_o !== 2'(exp_id[s]) || result_o !== W'(10 + 4*s) || count_o !== 3'd2 || grant_o !== 4'b0) begin
                bad++; $display("FAIL alt_done s=%0d got done=%0b id=%0d res=%0d cnt=%0d gnt=%0h want 1 %0d %0d 2 0",
                                s, done_o, done_id_o, result_o, count_o, grant_o, exp_id[s], 10 + 4*s);
            end
        end
    endtask

    task automatic test_three_samples();
        int n;
        req_i = 4'b0010;
        wait_grant(n);
        req_i = '0;
        total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL three_grant got=%0h want=2", grant_o); end
        drive(1, 10'd100, 1'b0); #1;
        total++; if (rf_go_o !== 1'b1 || rf_finish_o !== 1'b0 || rf_data_o !== 10'd100) begin
            bad++; $display("FAIL three_first go=%0b fin=%0b data=%0d want 1 0 100", rf_go_o, rf_finish_o, rf_data_o);
        end
        @(negedge clk); drive(1, 10'd40, 1'b0); #1;
        total++; if (rf_go_o !== 1'b0 || rf_finish_o !== 1'b0) begin
            bad++; $display("FAIL three_mid go=%0b fin=%0b want 0 0", rf_go_o, rf_finish_o);
        end
        @(negedge clk); drive(1, 10'd300, 1'b1); #1;
        total++; if (rf_finish_o !== 1'b1 || rf_go_o !== 1'b0) begin
            bad++; $display("FAIL three_last go=%0b fin=%0b want 0 1", rf_go_o, rf_finish_o);
        end
        @(negedge clk); idle_in();
        total++; if (done_o !== 1'b1 || done_id_o !== 2'd1 || result_o !== 10'd260 || count_o !== 3'd3 ||
                     result_err_o !== 1'b0 || result_trunc_o !== 1'b0) begin
            bad++; $display("FAIL three_done got done=%0b id=%0d res=%0d cnt=%0d err=%0b trunc=%0b want 1 1 260 3 0 0",
                            done_o, done_id_o, result_o, count_o, result_err_o, result_trunc_o);
        end
        @(negedge clk);
        total++; if (done_o !== 1'b0 || result_o !== 10'd260) begin
            bad++; $display("FAIL three_hold got done=%0b res=%0d want 0 260", done_o, result_o);
        end
    endtask

    task automatic test_single();
        int n;
        req_i = 4'b0100;
        wait_grant(n);
        req_i = '0;
        total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL single_grant got=%0h want=4", grant_o); end
        drive(2, 10'd77, 1'b1); #1;
        total++; if (rf_go_o !== 1'b1 || rf_finish_o !== 1'b0) begin
            bad++; $display("FAIL single_go go=%0b fin=%0b want 1 0", rf_go_o, rf_finish_o);
        end
        @(negedge clk); idle_in(); #1;
        total++; if (rf_finish_o !== 1'b1 || rf_data_o !== 10'd77 || ready_o !== 1'b0 || rf_go_o !== 1'b0) begin
            bad++; $display("FAIL single_close fin=%0b data=%0d rdy=%0b go=%0b want 1 77 0 0", rf_finish_o, rf_data_o, ready_o, rf_go_o);
        end
        @(negedge clk);
        total++; if (done_o !== 1'b1 || done_id_o !== 2'd2 || result_o !== 10'd0 || count_o !== 3'd1) begin
            bad++; $display("FAIL single_done got done=%0b id=%0d res=%0d cnt=%0d want 1 2 0 1", done_o, done_id_o, result_o, count_o);
        end
    endtask

    task automatic test_cap();
        int n;
        logic [W-1:0] vals[4] = '{10'd10, 10'd20, 10'd30, 10'd40};
        req_i = 4'b0001;
        wait_grant(n);
        req_i = '0;
        for (int k = 0; k < 4; k++) begin
            drive(0, vals[k], 1'b0); #1;
            total++; if (rf_finish_o !== (k == 3)) begin
                bad++; $display("FAIL cap_finish k=%0d got=%0b want=%0b", k, rf_finish_o, k == 3);
            end
            @(negedge clk);
        end
        drive(0, 10'd50, 1'b0); #1;
        total++; if (ready_o !== 1'b0 || rf_go_o !== 1'b0 || rf_finish_o !== 1'b0) begin
            bad++; $display("FAIL cap_fifth rdy=%0b go=%0b fin=%0b want 0 0 0", ready_o, rf_go_o, rf_finish_o);
        end
        total++; if (done_o !== 1'b1 || result_o !== 10'd30 || result_trunc_o !== 1'b1 || count_o !== 3'd4) begin
            bad++; $display("FAIL cap_done got done=%0b res=%0d trunc=%0b cnt=%0d want 1 30 1 4", done_o, result_o, result_trunc_o, count_o);
        end
        @(negedge clk); idle_in();
    endtask

    task automatic test_error();
        int n;
        req_i = 4'b0010;
        wait_grant(n);
        req_i = '0;
        drive(1, 10'd8, 1'b0);
        @(negedge clk); drive(1, 10'd3, 1'b1); rf_error_i = 1'b1;
        @(negedge clk); idle_in(); rf_error_i = 1'b0;
        total++; if (done_o !== 1'b1 || result_err_o !== 1'b1 || result_o !== 10'd5 || result_trunc_o !== 1'b0) begin
            bad++; $display("FAIL err_done got done=%0b err=%0b res=%0d trunc=%0b want 1 1 5 0", done_o, result_err_o, result_o, result_trunc_o);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        req_i = 4'b0010;
        wait_grant(n);
        drive(1, 10'd11, 1'b0);
        @(negedge clk); drive(1, 10'd12, 1'b0);
        @(negedge clk); idle_in(); reset_i = 1'b1; req_i = 4'b0101;
        @(negedge clk); reset_i = 1'b0;
        total++; if (grant_o !== 4'b0 || done_o !== 1'b0 || result_o !== '0) begin
            bad++; $display("FAIL mrst_clear got gnt=%0h done=%0b res=%0d want 0 0 0", grant_o, done_o, result_o);
        end
        wait_grant(n);
        total++; if (grant_o !== 4'b0001 || done_o !== 1'b0) begin
            bad++; $display("FAIL mrst_regrant got gnt=%0h done=%0b want 1 0", grant_o, done_o);
        end
        req_i = '0;
        drive(0, 10'd9, 1'b1);
        @(negedge clk); idle_in();
        @(negedge clk);
        total++; if (done_o !== 1'b1 || done_id_o !== 2'd0 || count_o !== 3'd1) begin
            bad++; $display("FAIL mrst_done got done=%0b id=%0d cnt=%0d want 1 0 1", done_o, done_id_o, count_o);
        end
    endtask

    task automatic test_gap();
        int n;
        req_i = 4'b0010;
        wait_grant(n);
        req_i = '0;
        drive(1, 10'd5, 1'b0);
        @(negedge clk); idle_in();
`ifdef RANGE_SCHED_TIMEOUT_EN
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (rf_go_o !== 1'b0 || rf_finish_o !== 1'b0) begin
                bad++; $display("FAIL gap_idle k=%0d go=%0b fin=%0b want 0 0", k, rf_go_o, rf_finish_o);
            end
            @(negedge clk);
        end
        #1;
        total++; if (rf_finish_o !== 1'b1 || rf_data_o !== 10'd5 || ready_o !== 1'b0) begin
            bad++; $display("FAIL gap_tmo_close fin=%0b data=%0d rdy=%0b want 1 5 0", rf_finish_o, rf_data_o, ready_o);
        end
        @(negedge clk);
        total++; if (done_o !== 1'b1 || result_err_o !== 1'b1 || result_o !== 10'd0 || count_o !== 3'd1) begin
            bad++; $display("FAIL gap_tmo_done got done=%0b err=%0b res=%0d cnt=%0d want 1 1 0 1", done_o, result_err_o, result_o, count_o);
        end
`else
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (rf_go_o !== 1'b0 || rf_finish_o !== 1'b0 || rf_data_o !== 10'd5) begin
                bad++; $display("FAIL gap_idle k=%0d go=%0b fin=%0b data=%0d want 0 0 5", k, rf_go_o, rf_finish_o, rf_data_o);
            end
            @(negedge clk);
        end
        drive(1, 10'd900, 1'b1); #1;
        total++; if (rf_finish_o !== 1'b1) begin bad++; $display("FAIL gap_finish got=%0b want=1", rf_finish_o); end
        @(negedge clk); idle_in();
        total++; if (done_o !== 1'b1 || result_o !== 10'd895 || result_err_o !== 1'b0 || count_o !== 3'd2) begin
            bad++; $display("FAIL gap_done got done=%0b res=%0d err=%0b cnt=%0d want 1 895 0 2", done_o, result_o, result_err_o, count_o);
        end
`endif
    endtask

`ifdef RANGE_SCHED_TIMEOUT_EN
    task automatic test_first_timeout();
        int n;
        req_i = 4'b0100;
        wait_grant(n);
        req_i = '0;
        total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL ftmo_grant got=%0h want=4", grant_o); end
        @(negedge clk); @(negedge clk);
        total++; if (grant_o !== 4'b0 || done_o !== 1'b0) begin
            bad++; $display("FAIL ftmo_abort got gnt=%0h done=%0b want 0 0", grant_o, done_o);
        end
        req_i = 4'b0110;
        wait_grant(n);
        req_i = '0;
        total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL ftmo_ptr got=%0h want=2", grant_o); end
        drive(1, 10'd7, 1'b1);
        @(negedge clk); idle_in();
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_alternate();
        test_three_samples();
        test_single();
        test_cap();
        test_error();
        test_mid_reset();
        test_gap();
`ifdef RANGE_SCHED_TIMEOUT_EN
        test_first_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/range_session_sched.md
Name: range_session_sched

Overview:
Schedules measurement sessions on the single shared range-finder datapath among NREQ requesters using round-robin arbitration. The granted requester streams samples into the block. The block drives the datapath's go/finish/data inputs, counts samples, captures range and error at session close, and returns one result per session with a done pulse. It sits between the chip io decode and the range-finder instance.

Parameters:
NREQ, 4, number of requesters
WIDTH, 10, sample/range width
MAX_SAMPLES, 255, sample cap per session; CNTW = $clog2(MAX_SAMPLES+1)
TIMEOUT, 16, idle-cycle limit (used only with optional feature)

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high
req  input  NREQ  per-requester session request
valid  input  NREQ  per-requester sample valid
last  input  NREQ  final sample of session, qualified by valid
data  input  NREQ*WIDTH  packed samples, requester i at [i*WIDTH +: WIDTH]
grant  output  NREQ  one-hot current session owner, 0 when none
ready  output  1  sample accepted when valid[g] & ready
rf_data  output  WIDTH  to datapath data_in
rf_go  output  1  to datapath go
rf_finish  output  1  to datapath finish
rf_range  input  WIDTH  datapath range; combinational over current rf_data
rf_error  input  1  datapath debug_error
done  output  1  one-cycle result strobe
done_id  output  $clog2(NREQ)  requester index of result
result  output  WIDTH  captured range
result_err  output  1  rf_error seen, or timeout abort
result_trunc  output  1  session closed by MAX_SAMPLES cap
count  output  CNTW  samples accepted in the reported session

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer = NREQ-1 so requester 0 wins first. Reset mid-session aborts with no done; the datapath shares the same reset.
- States: IDLE, FIRST, STREAM, CLOSE, REPORT.
- IDLE: if any req, arbitrate from pointer+1 upward, mod NREQ. Register grant and index g, then go to FIRST.
- FIRST: ready=1. On valid[g]: rf_data=data[g], rf_go=1 that cycle, count=1, hold the sample. If last[g] is also set, go to CLOSE (go and finish are never asserted together). Otherwise go to STREAM.
- STREAM: ready=1. On valid[g]: rf_data=data[g], count+1.
  - If last[g], or count reaches MAX_SAMPLES (set trunc): rf_finish=1 the same cycle, capture rf_range and go to REPORT; ready=0 from the next cycle.
- CLOSE: ready=0. Re-present the held sample with rf_finish=1, capture rf_range, go to REPORT. A duplicate sample leaves min/max unchanged.
- Gaps (valid low in FIRST/STREAM): rf_data holds the last accepted sample; rf_go=rf_finish=0.
- REPORT: done=1 for one cycle with done_id=g, result, result_err = rf_error | timeout flag, result_trunc, count. Result fields hold until the next done. grant=0, pointer=g, then go to IDLE.
- Latency: done asserts 1 cycle after the finish cycle.
- req deasserting mid-session is ignored; the session ends only via last, cap or timeout. A holder re-requesting has lowest priority at the next arbitration.
- count never wraps because of the cap.

Optional Feature:
RANGE_SCHED_TIMEOUT_EN.
- Defined: a counter tracks consecutive cycles in FIRST/STREAM with no accepted sample.
  - At TIMEOUT in FIRST: return to IDLE, no done, pointer=g.
  - At TIMEOUT in STREAM: go to CLOSE with result_err forced to 1.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Package range_sched_pkg: state enum, CNTW/IDW width helper functions.
- One sub-module, rr_arbiter: req and pointer in, one-hot grant plus index out; combinational, NREQ-parameterised.

Test Plan:
- req[1] samples 100, 40, 300(last) -> rf_go on 100, rf_finish on 300, next cycle done=1, done_id=1, result=260, count=3, err=0, trunc=0.
- req[2] single sample 77 with last -> rf_go cycle, then CLOSE cycle rf_finish with rf_data=77; result=0, count=1.
- req[0] and req[3] held high, 2-sample sessions -> grant order 0,3,0,3; no idle grant overlap.
- MAX_SAMPLES=4, requester offers 5 samples 10,20,30,40,50 -> finish on 40, ready low for 50, result=30, trunc=1, count=4.
- Reset for 1 cycle after 2 samples in STREAM -> grant=0, done never pulses; with req[0] and req[2] high, next grant is 0.
- Samples 5,(gap 3 cycles),900(last) -> rf_go/rf_finish low during gap, result=895; with RANGE_SCHED_TIMEOUT_EN and TIMEOUT=2 the same gap gives CLOSE, result_err=1, result=0.
